// File: rtl/keyboard_pkg.sv
// Shared definitions for the hex-key PS/2 style keyboard transmitter.
package keyboard_pkg;

    // Serial transmitter states
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GAP
    } tx_state_t;

    // Break prefix sent ahead of the make code on key release
    localparam logic [7:0] BREAK_CODE = 8'hF0;

    // Pending byte storage; a release needs two slots, a press needs one
    localparam int QUEUE_DEPTH = 3;

    // Set 2 make codes for the hex digit keys, indexed by key number 0..F
    localparam logic [15:0][7:0] SCAN_TABLE = {
        8'h2B, 8'h24, 8'h23, 8'h21, 8'h32, 8'h1C, 8'h46, 8'h3E,
        8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
    };

endpackage

// File: rtl/keyboard_debounce.sv
// Button conditioner: two-flop synchronizer followed by a stable-time counter.
// The accepted level only moves after the synchronized input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; rise/fall pulse for one
// cycle together with the level change.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing cycles; any agreement restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                    rise  <= sync2;
                    fall  <= ~sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/keyboard.sv
// Single-button hex keyboard: debounced press/release events become set 2
// make/break bytes, queued and shifted out as 11-bit odd-parity frames.
module keyboard
    import keyboard_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = CLK_HZ / 1_000,
    parameter int BIT_CYCLES      = CLK_HZ / 10_000,
    parameter int GAP_BITS        = 2
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic sw1,
    input  logic sw2,
    input  logic sw3,
    input  logic sw4,
    input  logic btn,
    output logic out
);

    localparam int GAP_CYCLES = ((GAP_BITS > 0) ? GAP_BITS : 1) * BIT_CYCLES;
    localparam int TW         = $clog2(GAP_CYCLES + BIT_CYCLES + 1);

    logic       btn_level;
    logic       btn_rise;
    logic       btn_fall;
    logic [3:0] key_idx;

    logic [7:0] q     [QUEUE_DEPTH];
    logic [7:0] q_n   [QUEUE_DEPTH];
    logic [1:0] q_cnt;
    logic [1:0] cnt_n;
    logic [1:0] base;
    logic [1:0] push_n;
    logic [7:0] push_b0;
    logic       press_ok;
    logic       release_ok;
    logic       pop;

    tx_state_t  state;
    logic [TW-1:0] timer;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       par_bit;
    logic       bit_done;
    logic       gap_done;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (sysclk),
        .rst_n(rst_n),
        .din  (btn),
        .level(btn_level),
        .rise (btn_rise),
        .fall (btn_fall)
    );

    // Events are accepted only when the whole sequence fits; otherwise dropped
    assign press_ok   = btn_rise & btn_level & (q_cnt <= 2'(QUEUE_DEPTH - 1));
    assign release_ok = btn_fall & ~btn_level & (q_cnt <= 2'(QUEUE_DEPTH - 2));
    assign push_n     = press_ok ? 2'd1 : (release_ok ? 2'd2 : 2'd0);
    assign push_b0    = press_ok ? SCAN_TABLE[{sw4, sw3, sw2, sw1}] : BREAK_CODE;

    assign bit_done = (timer == TW'(BIT_CYCLES - 1));
    assign gap_done = (timer == TW'(GAP_CYCLES - 1));
    assign pop      = (q_cnt != 2'd0) &&
                      ((state == IDLE) || ((state == GAP) && gap_done));

    // Next queue contents: head pop shifts down, pushes append after survivors
    always_comb begin
        q_n   = q;
        cnt_n = q_cnt;
        if (pop) begin
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) q_n[i] = q[i+1];
            cnt_n = q_cnt - 2'd1;
        end
        base = cnt_n;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if ((push_n != 2'd0) && (base == 2'(i)))
                q_n[i] = push_b0;
            if ((push_n == 2'd2) && ((base + 2'd1) == 2'(i)))
                q_n[i] = SCAN_TABLE[key_idx];
        end
        cnt_n = base + push_n;
    end

    // Queue storage and the key latched at press time for the later break
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) q[i] <= '0;
            q_cnt   <= '0;
            key_idx <= '0;
        end else begin
            q     <= q_n;
            q_cnt <= cnt_n;
            if (btn_rise) key_idx <= {sw4, sw3, sw2, sw1};
        end
    end

    // Frame transmitter: start, 8 data LSB first, odd parity, stop, gap
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            out     <= 1'b1;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out   <= 1'b1;
                    timer <= '0;
                    if (pop) begin
                        shreg   <= q[0];
                        par_bit <= ~^q[0];
                        state   <= START;
                        out     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        out     <= shreg[0];
                        state   <= DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            out   <= par_bit;
                            state <= PARITY;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= shreg >> 1;
                            out     <= shreg[1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        timer <= '0;
                        out   <= 1'b1;
                        state <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        timer <= '0;
                        state <= GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        timer <= '0;
                        if (pop) begin
                            shreg   <= q[0];
                            par_bit <= ~^q[0];
                            out     <= 1'b0;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    out   <= 1'b1;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keyboard.sv
// Directed bench for keyboard with shortened timing parameters.
module tb_keyboard;

    localparam int DEB  = 20;
    localparam int BIT  = 10;
    localparam int GAPB = 2;
    localparam int FRAME_PERIOD = (11 + GAPB) * BIT;

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] sw     = 4'h0;
    logic       btn    = 1'b0;
    logic       out;
    int         cyc    = 0;
    int         tests  = 0;
    int         fails  = 0;

    keyboard #(
        .CLK_HZ         (100_000),
        .DEBOUNCE_CYCLES(DEB),
        .BIT_CYCLES     (BIT),
        .GAP_BITS       (GAPB)
    ) dut (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .sw1   (sw[0]),
        .sw2   (sw[1]),
        .sw3   (sw[2]),
        .sw4   (sw[3]),
        .btn   (btn),
        .out   (out)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    // Expected frame, bit 0 = start bit: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // Wait for a start bit and sample each bit at its first and last cycle
    task automatic rx_frame(input int timeout, output logic [10:0] bits,
                            output int t_fall, output bit ok);
        bit found = 1'b0;
        logic a, b;
        bits = '1; t_fall = 0; ok = 1'b0;
        for (int w = 0; w < timeout && !found; w++) begin
            @(negedge sysclk);
            if (out === 1'b0) found = 1'b1;
        end
        if (!found) return;
        t_fall = cyc;
        ok = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge sysclk);
            a = out;
            repeat (BIT - 1) @(negedge sysclk);
            b = out;
            if (a !== b) ok = 1'b0;
            bits[i] = a;
        end
    endtask

    task automatic count_low(input int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge sysclk);
            if (out !== 1'b1) lows++;
        end
    endtask

    task automatic test_reset;
        int lows;
        rst_n = 1'b0; btn = 1'b0; sw = 4'h0;
        repeat (3) @(negedge sysclk);
        tests++;
        if (out !== 1'b1) begin fails++; $display("FAIL reset_out: got %b want 1", out); end
        rst_n = 1'b1;
        count_low(50, lows);
        tests++;
        if (lows !== 0) begin fails++; $display("FAIL reset_idle: low cycles %0d want 0", lows); end
    endtask

    task automatic test_short_pulse;
        int lows;
        btn = 1'b1;
        repeat (15) @(negedge sysclk);
        btn = 1'b0;
        count_low(200, lows);
        tests++;
        if (lows !== 0) begin fails++; $display("FAIL short_pulse: low cycles %0d want 0", lows); end
    endtask

    task automatic test_make_break;
        logic [10:0] f; int t0, t1, t2, lows; bit ok;
        sw = 4'h0;
        @(negedge sysclk);
        btn = 1'b1; t0 = cyc;
        rx_frame(200, f, t1, ok);
        tests++;
        if (!ok || f !== 11'b100_1000_1010) begin
            fails++; $display("FAIL make_45: got %b ok=%0d want %b", f, ok, 11'b100_1000_1010);
        end
        tests++;
        if ((t1 - t0) < DEB || (t1 - t0) > DEB + 6) begin
            fails++; $display("FAIL press_latency: got %0d want %0d..%0d", t1 - t0, DEB, DEB + 6);
        end
        count_low(300, lows);
        tests++;
        if (lows !== 0) begin fails++; $display("FAIL no_repeat: low cycles %0d want 0", lows); end
        btn = 1'b0;
        rx_frame(200, f, t1, ok);
        tests++;
        if (!ok || f !== frame_of(8'hF0)) begin fails++; $display("FAIL break_f0: got %b want %b", f, frame_of(8'hF0)); end
        rx_frame(200, f, t2, ok);
        tests++;
        if (!ok || f !== frame_of(8'h45)) begin fails++; $display("FAIL break_45: got %b want %b", f, frame_of(8'h45)); end
        tests++;
        if ((t2 - t1) !== FRAME_PERIOD) begin
            fails++; $display("FAIL frame_spacing: got %0d want %0d", t2 - t1, FRAME_PERIOD);
        end
        count_low(50, lows);
    endtask

    task automatic test_switch_latch;
        logic [10:0] f; int t, lows; bit ok;
        sw = 4'b0001;
        @(negedge sysclk);
        btn = 1'b1;
        rx_frame(200, f, t, ok);
        tests++;
        if (!ok || f !== frame_of(8'h16)) begin fails++; $display("FAIL make_16: got %b want %b", f, frame_of(8'h16)); end
        tests++;
        if (f[9] !== 1'b0) begin fails++; $display("FAIL parity_16: got %b want 0", f[9]); end
        sw = 4'b1111;
        repeat (50) @(negedge sysclk);
        btn = 1'b0;
        rx_frame(200, f, t, ok);
        tests++;
        if (!ok || f !== frame_of(8'hF0)) begin fails++; $display("FAIL latch_f0: got %b want %b", f, frame_of(8'hF0)); end
        rx_frame(200, f, t, ok);
        tests++;
        if (!ok || f !== frame_of(8'h16)) begin fails++; $display("FAIL latch_16: got %b want %b", f, frame_of(8'h16)); end
        sw = 4'h0;
        count_low(50, lows);
    endtask

    task automatic test_bounce;
        logic [10:0] f; int t, lows; bit ok;
        sw = 4'hA;
        for (int i = 0; i < 8; i++) begin
            btn = ~btn;
            repeat (5) @(negedge sysclk);
        end
        btn = 1'b1;
        rx_frame(200, f, t, ok);
        tests++;
        if (!ok || f !== frame_of(8'h1C)) begin fails++; $display("FAIL bounce_make: got %b want %b", f, frame_of(8'h1C)); end
        count_low(300, lows);
        tests++;
        if (lows !== 0) begin fails++; $display("FAIL bounce_single: low cycles %0d want 0", lows); end
        btn = 1'b0;
        rx_frame(200, f, t, ok);
        rx_frame(200, f, t, ok);
        tests++;
        if (!ok || f !== frame_of(8'h1C)) begin fails++; $display("FAIL bounce_break: got %b want %b", f, frame_of(8'h1C)); end
        sw = 4'h0;
        count_low(50, lows);
    endtask

    // Press, release, press, release in quick succession while the first
    // frame is on the wire: the second release finds the queue full.
    task automatic test_overflow;
        logic [10:0] f [4]; int t, lows; bit ok [4];
        logic [7:0] exp [4];
        exp[0] = 8'h45; exp[1] = 8'hF0; exp[2] = 8'h45; exp[3] = 8'h16;
        sw = 4'h0;
        @(negedge sysclk);
        fork
            begin
                btn = 1'b1; repeat (30) @(negedge sysclk);
                btn = 1'b0; repeat (15) @(negedge sysclk);
                sw  = 4'h1; repeat (15) @(negedge sysclk);
                btn = 1'b1; repeat (30) @(negedge sysclk);
                btn = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) rx_frame(300, f[i], t, ok[i]);
            end
        join
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (!ok[i] || f[i] !== frame_of(exp[i])) begin
                fails++; $display("FAIL overflow_frame%0d: got %b want %b", i, f[i], frame_of(exp[i]));
            end
        end
        count_low(300, lows);
        tests++;
        if (lows !== 0) begin fails++; $display("FAIL overflow_dropped: low cycles %0d want 0", lows); end
        sw = 4'h0;
    endtask

    task automatic test_reset_mid_frame;
        bit found = 1'b0; int lows;
        sw = 4'h0;
        @(negedge sysclk);
        btn = 1'b1;
        for (int w = 0; w < 200 && !found; w++) begin
            @(negedge sysclk);
            if (out === 1'b0) found = 1'b1;
        end
        tests++;
        if (!found) begin fails++; $display("FAIL midreset_start: no start bit within 200 cycles"); end
        repeat (2 * BIT + BIT / 2) @(negedge sysclk);
        tests++;
        if (out !== 1'b0) begin fails++; $display("FAIL midreset_d1: got %b want 0", out); end
        rst_n = 1'b0;
        #1;
        tests++;
        if (out !== 1'b1) begin fails++; $display("FAIL midreset_out: got %b want 1", out); end
        btn = 1'b0;
        repeat (5) @(negedge sysclk);
        rst_n = 1'b1;
        count_low(300, lows);
        tests++;
        if (lows !== 0) begin fails++; $display("FAIL midreset_quiet: low cycles %0d want 0", lows); end
    endtask

    task automatic test_reset_btn_high;
        logic [10:0] f; int t0, t1, lows; bit ok;
        rst_n = 1'b0; btn = 1'b1; sw = 4'h0;
        repeat (5) @(negedge sysclk);
        rst_n = 1'b1; t0 = cyc;
        rx_frame(200, f, t1, ok);
        tests++;
        if (!ok || f !== frame_of(8'h45)) begin fails++; $display("FAIL rst_btn_make: got %b want %b", f, frame_of(8'h45)); end
        tests++;
        if ((t1 - t0) < DEB || (t1 - t0) > DEB + 6) begin
            fails++; $display("FAIL rst_btn_latency: got %0d want %0d..%0d", t1 - t0, DEB, DEB + 6);
        end
        btn = 1'b0;
        rx_frame(200, f, t1, ok);
        rx_frame(200, f, t1, ok);
        tests++;
        if (!ok || f !== frame_of(8'h45)) begin fails++; $display("FAIL rst_btn_break: got %b want %b", f, frame_of(8'h45)); end
        count_low(50, lows);
    endtask

    initial begin
        test_reset;
        test_short_pulse;
        test_make_break;
        test_switch_latch;
        test_bounce;
        test_overflow;
        test_reset_mid_frame;
        test_reset_btn_high;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keyboard.md
KEYBOARD -- requirements
Module: keyboard

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50_000 (1 ms), required stable time of btn before a level change is accepted.
REQ-003 Parameter BIT_CYCLES, default 5_000 (100 us), duration of one serial bit on out.
REQ-004 Parameter GAP_BITS, default 2, idle-high bit times inserted between consecutive frames.
REQ-005 sysclk  input  1  sole clock, rising-edge active.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 sw1, sw2, sw3, sw4  input  1 each  key select; key index = {sw4,sw3,sw2,sw1}, 0..15.
REQ-008 btn  input  1  asynchronous, bouncy key-press button, high = pressed.
REQ-009 out  output  1  serial keyboard data line, idle high.

Function
REQ-010 btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 The debounced button state SHALL change only after the synchronized btn has differed from it for DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts the count.
REQ-012 A debounced 0->1 transition SHALL be a press event; a debounced 1->0 transition SHALL be a release event.
REQ-013 On a press event, the key index SHALL be latched and the make code SHALL be queued.
REQ-014 The make-code table (hex digit keys, PS/2 set 2) SHALL be: 0=45 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46 A=1C B=32 C=21 D=23 E=24 F=2B.
REQ-015 On a release event, the byte F0 followed by the make code of the latched index (not the current switches) SHALL be queued.
REQ-016 Each byte SHALL be sent as an 11-bit frame: start 0, 8 data bits LSB first, odd parity, stop 1; each bit held exactly BIT_CYCLES cycles.
REQ-017 Transmitter states: IDLE, START, DATA, PARITY, STOP, GAP; GAP holds out high for GAP_BITS*BIT_CYCLES cycles, then returns to IDLE or starts the next queued byte.
REQ-018 The first bit of a frame SHALL appear on out the cycle after the transmitter leaves IDLE; out SHALL be registered.
REQ-019 An event arriving while a frame is in progress SHALL be held pending and sent after GAP; frames SHALL never be truncated or interleaved.
REQ-020 Queue depth SHALL be 3 bytes; if an event would overflow it, the new event SHALL be dropped whole (no partial break sequence).
REQ-021 Switch changes while btn is pressed SHALL not affect any queued or in-flight byte.
REQ-022 No auto-repeat: holding btn SHALL produce exactly one make code.

Reset
REQ-023 While rst_n is low: out = 1, debounced state = 0, all counters = 0, queue empty, transmitter in IDLE, latched index = 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately; after release no partial frame resumes.
REQ-025 If btn is high when rst_n deasserts, a press event SHALL follow after DEBOUNCE_CYCLES.

Structure
REQ-026 A shared package SHALL hold the transmitter state enum, the 16-entry scan-code table and the F0 break-prefix constant.
REQ-027 A single sub-module, debounce (synchronizer + stable counter, outputs level plus rise/fall pulses), SHALL be instantiated; framing, queue and table stay in keyboard.

Verification
REQ-028 btn high for 300 cycles then low -> no press event, out stays 1.
REQ-029 switches 0000, btn held 4 ms -> one frame 0x45 (bits 0,1,0,1,0,0,0,1,0,0,1) starting ~1 ms after press, each bit 5_000 cycles.
REQ-030 release of REQ-029 -> frames F0 then 45, separated by 10_000 idle-high cycles.
REQ-031 sw1=1 (index 1), press -> 0x16, parity bit 0; change switches to 1111 before release -> break sends F0,16.
REQ-032 btn bouncing (toggle every 10 us for 200 us) then steady high -> exactly one make frame.
REQ-033 rst_n pulsed low mid DATA bit -> out = 1 within the same cycle, no further frame until a new event.
